seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Unsigned multi-cycle restoring divider, the inverse of the team's adder datapath.
//  Each iteration is a trial subtraction built from one carry_lookahead_adder instance:
//  WIDTH+1 bits wide, cin=1, divisor inverted.
//  Produces one quotient bit per clock. Valid/ready handshakes on both sides let it sit
//  between a register-file/UART front end and downstream ALU result muxing.
// PARAMETERS
//  WIDTH  8  operand, quotient and remainder width in bits (>=2)
// PORTS
//  Clock and reset: one clock, i_clk; reset i_rst_n is asynchronous and active-low.
//  i_clk       in   1      clock, all state updates on rising edge
//  i_rst_n     in   1      asynchronous active-low reset
//  i_valid     in   1      operands valid
//  o_ready     out  1      divider can accept operands (IDLE only)
//  i_dividend  in   WIDTH  dividend, sampled on accept
//  i_divisor   in   WIDTH  divisor, sampled on accept
//  o_valid     out  1      result valid (DONE only)
//  i_ready     in   1      downstream accepts result
//  o_quotient  out  WIDTH  quotient
//  o_remainder out  WIDTH  remainder
//  o_div_zero  out  1      divisor was zero (only when DIV_ZERO_ERR_EN defined)
// BEHAVIOUR
//  - Reset: state=IDLE, o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, o_div_zero=0,
//    internal count/registers=0. Reset mid-operation aborts; the partial result is discarded.
//  - FSM IDLE -> BUSY on accept (i_valid & o_ready at edge).
//    Accept latches the dividend into the shift register, the divisor into a register,
//    clears the partial remainder, and sets count=WIDTH-1.
//  - BUSY, one edge per bit, MSB first:
//    r' = {rem[WIDTH-1:0], dvd[WIDTH-1]}  (WIDTH+1 bits)
//    t  = r' - {1'b0, divisor}
//    if no borrow (t[WIDTH]==0): rem=t, qbit=1; else rem=r', qbit=0.
//    The dividend shift register shifts left and inserts qbit at the LSB; the register then
//    holds the quotient after WIDTH steps.
//    When count==0 at the edge: -> DONE. Otherwise count decrements.
//  - Latency: o_valid rises exactly WIDTH cycles after the accept edge.
//    Throughput: one op per WIDTH+2 cycles with i_ready held high.
//  - DONE: o_valid=1. o_quotient/o_remainder stay stable until the handshake.
//    On i_ready & o_valid: -> IDLE, o_valid=0. Outputs keep the last result.
//    While i_ready=0: hold indefinitely.
//  - o_ready=0 in BUSY and DONE. No accept in the same cycle as result handoff;
//    i_valid during BUSY/DONE is ignored (no sampling).
//  - Divisor 0 (base build) falls out of the algorithm: quotient = all ones,
//    remainder = dividend, full WIDTH-cycle latency.
//  - Dividend < divisor: quotient=0, remainder=dividend. Divisor 1: quotient=dividend, remainder=0.
//  - Max values: 2^WIDTH-1 / 2^WIDTH-1 gives q=1, r=0. No overflow is possible in unsigned mode.
// CONFIGURATION
//  DIV_ZERO_ERR_EN defined:
//  - Adds port o_div_zero.
//  - On accept with i_divisor==0: skip BUSY, go IDLE -> DONE at the next edge (latency 1).
//  - Result: o_quotient = all ones, o_remainder = dividend, o_div_zero=1.
//  - o_div_zero clears on the next accept, or on reset.
//  DIV_ZERO_ERR_EN undefined:
//  - No o_div_zero port.
//  - Divide-by-zero takes the normal WIDTH-cycle path with the same q/r values.
// TESTING (WIDTH=8)
//  1. 100/7, i_ready=1 -> o_valid exactly 8 cycles after accept; q=14, r=2; o_ready=1 next cycle.
//  2. 255/1, then 5/9 back-to-back -> q=255,r=0, then q=0,r=5; o_ready low throughout BUSY/DONE.
//  3. 200/0 -> q=255, r=200.
//     With DIV_ZERO_ERR_EN: o_div_zero=1 and o_valid 1 cycle after accept.
//     Without it: 8-cycle latency.
//  4. 255/255 with i_ready=0 for 5 cycles after o_valid -> q=1, r=0 held stable;
//     accept leaves DONE on the first i_ready=1 edge.
//  5. Assert i_rst_n=0 at cycle 4 of a BUSY op (async, mid-cycle) -> immediately IDLE,
//     o_valid=0, outputs 0. The next op 9/3 gives q=3, r=0.
//  6. Toggle i_valid/operands while BUSY -> ignored; the result matches the operands at the accept edge.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock; a divisor of zero gives q=all ones, r=dividend.
// Latency WIDTH cycles from accept to o_valid (1 cycle for divide-by-zero when DIV_ZERO_ERR_EN is defined).
// Backpressure: o_ready only in IDLE; the result holds in DONE until i_ready is seen.

module carry_lookahead_adder #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o
);
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] carry;
    logic             acc;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Each carry is expanded from cin and generate/propagate, not taken from the neighbouring carry.
    always_comb begin
        carry = '0;
        acc   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = cin_i;
            for (int j = 0; j < i; j++) begin
                acc = gen[j] | (prop[j] & acc);
            end
            carry[i] = acc;
        end
    end

    assign sum_o = prop ^ carry;
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic             o_div_zero
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef DIV_ZERO_ERR_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_sum;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;

    // Trial subtraction r' - divisor as r' + ~{0,divisor} + 1; bit WIDTH set means borrow.
    assign trial_a = {rem_q, dvd_q[WIDTH-1]};

    carry_lookahead_adder #(.WIDTH(WIDTH + 1)) u_trial (
        .a_i   (trial_a),
        .b_i   (~{1'b0, dsr_q}),
        .cin_i (1'b1),
        .sum_o (trial_sum)
    );

    assign qbit     = ~trial_sum[WIDTH];
    assign rem_step = qbit ? trial_sum[WIDTH-1:0] : trial_a[WIDTH-1:0];
    assign dvd_step = {dvd_q[WIDTH-2:0], qbit};

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        cnt_d     = cnt_q;
`ifdef DIV_ZERO_ERR_EN
        dz_d      = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    dvd_d   = i_dividend;
                    dsr_d   = i_divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_BUSY;
`ifdef DIV_ZERO_ERR_EN
                    // Zero divisor: one pass through BUSY with count 0 finishes the op.
                    dz_d = (i_divisor == '0);
                    if (i_divisor == '0) begin
                        cnt_d = '0;
                    end
`endif
                end
            end
            S_BUSY: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                if (cnt_q == '0) begin
                    state_d   = S_DONE;
                    quo_d     = dvd_step;
                    res_rem_d = rem_step;
`ifdef DIV_ZERO_ERR_EN
                    if (dz_q) begin
                        quo_d     = '1;
                        res_rem_d = dvd_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
            cnt_q     <= '0;
`ifdef DIV_ZERO_ERR_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
            cnt_q     <= cnt_d;
`ifdef DIV_ZERO_ERR_EN
            dz_q      <= dz_d;
`endif
        end
    end

    assign o_ready     = (state_q == S_IDLE);
    assign o_valid     = (state_q == S_DONE);
    assign o_quotient  = quo_q;
    assign o_remainder = res_rem_q;
`ifdef DIV_ZERO_ERR_EN
    assign o_div_zero  = dz_q;
`endif
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised and directed bench for seq_restoring_divider (WIDTH=8) against an arithmetic reference.
// Builds with or without DIV_ZERO_ERR_EN.
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
`ifdef DIV_ZERO_ERR_EN
    logic         o_div_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
`ifdef DIV_ZERO_ERR_EN
        ,
        .o_div_zero  (o_div_zero)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : W'(int'(a) % int'(b));
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_ERR_EN
        return (b == 0) ? 1 : W;
`else
        return (b == 0) ? W : W;
`endif
    endfunction

    // Launch one op, optionally scribble on the inputs while busy, then hold the result for `hold` cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit noise);
        int lat;
        bit rdy_seen;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        @(negedge clk);
        i_valid = 1'b1;
        i_dividend = a;
        i_divisor = b;
        i_ready = (hold == 0);
        chk("ready_idle", o_ready, 1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        i_valid = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        while (!o_valid && lat < 50) begin
            if (noise) begin
                i_valid = 1'($urandom);
                i_dividend = W'($urandom);
                i_divisor = W'($urandom);
            end
            rdy_seen |= o_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        i_valid = 1'b0;
        chk("latency", lat, ref_lat(b));
        chk("ready_busy", rdy_seen, 0);
        chk("quotient", o_quotient, eq);
        chk("remainder", o_remainder, er);
`ifdef DIV_ZERO_ERR_EN
        chk("div_zero", o_div_zero, (b == 0));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", o_valid, 1);
            chk("hold_ready", o_ready, 0);
            chk("hold_q", o_quotient, eq);
            chk("hold_r", o_remainder, er);
        end
        if (hold > 0) begin
            @(negedge clk);
            i_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("handoff_valid", o_valid, 0);
        chk("handoff_ready", o_ready, 1);
        chk("kept_q", o_quotient, eq);
    endtask

    initial begin
        int acc0;
        #12;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_q", o_quotient, 0);
        chk("rst_r", o_remainder, 0);
`ifdef DIV_ZERO_ERR_EN
        chk("rst_dz", o_div_zero, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'd100, 8'd7, 0, 1'b0);
        do_op(8'd255, 8'd1, 0, 1'b0);
        acc0 = last_acc;
        do_op(8'd5, 8'd9, 0, 1'b0);
        chk("throughput", last_acc - acc0, W + 2);
        do_op(8'd200, 8'd0, 0, 1'b0);
        do_op(8'd255, 8'd255, 5, 1'b0);
        do_op(8'd77, 8'd13, 0, 1'b1);

        // Abort mid-operation with an asynchronous reset away from the clock edge.
        @(negedge clk);
        i_valid = 1'b1;
        i_dividend = 8'd100;
        i_divisor = 8'd7;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", o_ready, 1);
        chk("abort_valid", o_valid, 0);
        chk("abort_q", o_quotient, 0);
        chk("abort_r", o_remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd9, 8'd3, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 8'd1;
                2: b = a;
                default: b = W'($urandom);
            endcase
            do_op(a, b, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
